// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// access. One transaction is outstanding at a time. Data has priority over
// fetch, and a starvation counter periodically forces a fetch grant. A
// pipeline flush discards the response of a pending or in-flight fetch.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   // fetch side
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   // data side
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   // memory side
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   state_t      state, state_nx;
   owner_t      owner, owner_nx;
   logic        drop, drop_nx;
   logic [3:0]  starve_cnt, starve_nx;
   logic        we_q, we_nx;
   logic [31:0] addr_q, addr_nx;
   logic [31:0] wdata_q, wdata_nx;
   logic [3:0]  wstrb_q, wstrb_nx;
   logic        pick_i, pick_d;

   assign m_req   = (state == REQ);
   assign busy    = (state != IDLE);
   assign m_we    = we_q;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_wstrb = wstrb_q;

   // Arbitration, next-state and response generation.
   always_comb begin
      state_nx  = state;
      owner_nx  = owner;
      drop_nx   = drop;
      starve_nx = starve_cnt;
      we_nx     = we_q;
      addr_nx   = addr_q;
      wdata_nx  = wdata_q;
      wstrb_nx  = wstrb_q;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;

      pick_i = i_req && !i_flush && (!d_req || starve_cnt == STARVE_LIM);
      pick_d = d_req && !pick_i;

      case (state)
         IDLE: begin
            if (pick_i) begin
               i_gnt    = 1'b1;
               owner_nx = OWN_I;
               addr_nx  = i_addr;
               we_nx    = 1'b0;
               wdata_nx = '0;
               wstrb_nx = '0;
               drop_nx  = 1'b0;
               state_nx = REQ;
            end else if (pick_d) begin
               d_gnt    = 1'b1;
               owner_nx = OWN_D;
               addr_nx  = d_addr;
               we_nx    = d_we;
               wdata_nx = d_wdata;
               wstrb_nx = d_wstrb;
               drop_nx  = 1'b0;
               state_nx = REQ;
            end
            if (pick_i || !i_req)
               starve_nx = '0;
            else if (pick_d && starve_cnt < STARVE_LIM)
               starve_nx = starve_cnt + 4'd1;
         end
         REQ: begin
            if (owner == OWN_I && i_flush)
               drop_nx = 1'b1;
            if (m_gnt)
               state_nx = WAIT;
         end
         WAIT: begin
            if (owner == OWN_I && i_flush)
               drop_nx = 1'b1;
            if (m_rvalid) begin
               state_nx = IDLE;
               if (owner == OWN_D) begin
                  d_rvalid = 1'b1;
                  d_rdata  = we_q ? '0 : m_rdata;
               end else if (!drop && !i_flush) begin
                  i_rvalid = 1'b1;
                  i_rdata  = m_rdata;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // Pulses are suppressed while reset is asserted so an abandoned
      // transaction never reports a response or issues a grant.
      if (rst) begin
         i_gnt    = 1'b0;
         d_gnt    = 1'b0;
         i_rvalid = 1'b0;
         d_rvalid = 1'b0;
         i_rdata  = '0;
         d_rdata  = '0;
      end
   end

   // State and latched-command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_I;
         drop       <= 1'b0;
         starve_cnt <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         drop       <= drop_nx;
         starve_cnt <= starve_nx;
         we_q       <= we_nx;
         addr_q     <= addr_nx;
         wdata_q    <= wdata_nx;
         wstrb_q    <= wstrb_nx;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned SM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_flush, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        m_req, m_we, m_gnt, m_rvalid, busy;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;

   int tests = 0;
   int fails = 0;

   // reference model state
   int unsigned cnt = 0;   // consecutive data grants while fetch pending
   logic        exp_d;
   logic        exp_we;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;

   mem_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .busy(busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // watchdog so the run always terminates
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // check the command presented to memory while in REQ
   task automatic chk_cmd(input string tag);
      chk1({tag, "_m_req"}, m_req, 1'b1);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk32({tag, "_m_addr"}, m_addr, exp_addr);
      chk1({tag, "_m_we"}, m_we, exp_we);
      chk32({tag, "_m_wstrb"}, 32'(m_wstrb), 32'(exp_wstrb));
      if (exp_d) chk32({tag, "_m_wdata"}, m_wdata, exp_wdata);
   endtask

   // One IDLE cycle with the given requests; predicts and checks the winner.
   task automatic arb_cycle(input logic ir, input logic [31:0] ia, input logic fl,
                            input logic dr, input logic dwe, input logic [31:0] da,
                            input logic [31:0] dwd, input logic [3:0] ds,
                            output logic win_i, output logic granted);
      logic win_d;
      i_req = ir; i_addr = ia; i_flush = fl;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = ds;
      #1;
      // fetch wins when eligible and either alone or starved long enough
      win_i = ir && !fl && (!dr || cnt == SM);
      win_d = dr && !win_i;
      chk1("i_gnt", i_gnt, win_i);
      chk1("d_gnt", d_gnt, win_d);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_m_req", m_req, 1'b0);
      chk1("idle_i_rvalid", i_rvalid, 1'b0);
      chk1("idle_d_rvalid", d_rvalid, 1'b0);
      if (win_i || !ir) cnt = 0;
      else if (win_d && cnt < SM) cnt = cnt + 1;
      if (win_i) begin
         exp_d = 1'b0; exp_addr = ia; exp_we = 1'b0; exp_wdata = '0; exp_wstrb = '0;
      end else if (win_d) begin
         exp_d = 1'b1; exp_addr = da; exp_we = dwe; exp_wdata = dwd; exp_wstrb = ds;
      end
      granted = win_i || win_d;
      tick();
      i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
      d_addr = $urandom; d_wdata = $urandom; i_addr = $urandom;
   endtask

   // Memory side of one granted transaction, starting in the REQ cycle.
   // gd: stall cycles before m_gnt, rd: cycles between m_gnt and m_rvalid.
   // fl_early flushes before the response, fl_rv flushes in the response cycle.
   task automatic mem_phase(input int gd, input int rd, input logic fl_early,
                            input logic fl_rv, input logic [31:0] rdata);
      logic exp_iv;
      for (int k = 0; k < gd; k++) begin
         #1; chk_cmd("stall"); tick();
      end
      m_gnt = 1'b1;
      i_flush = fl_early && (rd == 0);
      #1; chk_cmd("mgnt"); tick();
      m_gnt = 1'b0; i_flush = 1'b0;
      for (int k = 0; k < rd; k++) begin
         i_flush = fl_early && (k == rd - 1);
         #1;
         chk1("wait_m_req", m_req, 1'b0);
         chk1("wait_busy", busy, 1'b1);
         chk1("wait_i_rvalid", i_rvalid, 1'b0);
         chk1("wait_d_rvalid", d_rvalid, 1'b0);
         tick();
      end
      m_rvalid = 1'b1; m_rdata = rdata; i_flush = fl_rv;
      #1;
      exp_iv = !exp_d && !fl_early && !fl_rv;
      chk1("rsp_i_rvalid", i_rvalid, exp_iv);
      chk1("rsp_d_rvalid", d_rvalid, exp_d);
      chk1("rsp_busy", busy, 1'b1);
      if (exp_iv) chk32("rsp_i_rdata", i_rdata, rdata);
      if (exp_d) chk32("rsp_d_rdata", d_rdata, exp_we ? 32'h0 : rdata);
      tick();
      m_rvalid = 1'b0; i_flush = 1'b0; m_rdata = $urandom;
   endtask

   logic wi, g;

   initial begin
      rst = 1'b1;
      i_req = 0; i_addr = 0; i_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      m_gnt = 0; m_rvalid = 0; m_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      // reset state
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_m_req", m_req, 1'b0);
      chk32("rst_m_addr", m_addr, 32'h0);
      chk1("rst_m_we", m_we, 1'b0);
      chk32("rst_m_wdata", m_wdata, 32'h0);
      chk32("rst_m_wstrb", 32'(m_wstrb), 32'h0);
      chk1("rst_i_gnt", i_gnt, 1'b0);
      chk1("rst_d_gnt", d_gnt, 1'b0);
      tick();

      // single fetch with minimum latency
      arb_cycle(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, wi, g);
      mem_phase(0, 0, 0, 0, 32'h0000_0013);

      // contention: D,D,D,D,I repeated
      for (int k = 0; k < 10; k++) begin
         arb_cycle(1, 32'h8000_0100, 0, 1, 0, 32'h8000_2000 + 32'(k * 4), 0, 0, wi, g);
         chk1("contention_order", wi, (k % 5) == 4);
         mem_phase(0, 0, 0, 0, $urandom);
      end

      // store with memory stalls; fields held until m_gnt, d_rdata = 0
      arb_cycle(0, 0, 0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, wi, g);
      mem_phase(2, 1, 0, 0, 32'h1234_5678);

      // flush while in WAIT, then a normal fetch
      arb_cycle(1, 32'h8000_0008, 0, 0, 0, 0, 0, 0, wi, g);
      mem_phase(0, 2, 1, 0, 32'hAAAA_5555);
      arb_cycle(1, 32'h8000_0010, 0, 0, 0, 0, 0, 0, wi, g);
      mem_phase(0, 0, 0, 0, 32'h0000_0093);

      // flush in the response cycle
      arb_cycle(1, 32'h8000_0014, 0, 0, 0, 0, 0, 0, wi, g);
      mem_phase(1, 1, 0, 1, 32'h0BAD_F00D);

      // flush alongside fetch request in IDLE: no grant; with data: data wins
      arb_cycle(1, 32'h8000_0018, 1, 0, 0, 0, 0, 0, wi, g);
      chk1("flush_idle_nogrant", g, 1'b0);
      arb_cycle(1, 32'h8000_0018, 1, 1, 0, 32'h8000_3000, 0, 0, wi, g);
      mem_phase(0, 0, 0, 0, 32'h0000_7777);

      // reset while in WAIT, then a stray m_rvalid
      arb_cycle(1, 32'h8000_0020, 0, 0, 0, 0, 0, 0, wi, g);
      m_gnt = 1'b1; tick(); m_gnt = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      cnt = 0;
      m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
      #1;
      chk1("rstw_i_rvalid", i_rvalid, 1'b0);
      chk1("rstw_d_rvalid", d_rvalid, 1'b0);
      chk1("rstw_busy", busy, 1'b0);
      chk1("rstw_m_req", m_req, 1'b0);
      chk32("rstw_m_addr", m_addr, 32'h0);
      chk32("rstw_i_rdata", i_rdata, 32'h0);
      chk32("rstw_d_rdata", d_rdata, 32'h0);
      tick();

      // stray m_rvalid and m_gnt in IDLE are ignored (IDLE with i_req low)
      m_gnt = 1'b1;
      #1;
      chk1("stray_i_rvalid", i_rvalid, 1'b0);
      chk1("stray_d_rvalid", d_rvalid, 1'b0);
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b0;
      cnt = 0;
      #1;
      chk1("stray_busy", busy, 1'b0);
      tick();

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         int unsigned pat;
         logic ir, dr, fl;
         pat = $urandom_range(0, 4);
         ir  = (pat == 0 || pat == 1 || pat == 3);
         dr  = (pat == 0 || pat == 2 || pat == 3);
         fl  = ($urandom_range(0, 7) == 0);
         arb_cycle(ir, $urandom, fl, dr, 1'($urandom), $urandom, $urandom,
                   4'($urandom), wi, g);
         if (g)
            mem_phase(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). Only one transaction is outstanding at a time. Data requests have priority, and a starvation counter guarantees fetch progress. Outstanding fetch responses are discarded when the pipeline flushes on a branch mispredict.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive data grants, while a fetch request is pending, after which fetch gets priority (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request.
- i_addr  in  32  fetch address.
- i_flush  in  1  mispredict flush; kills the pending or in-flight fetch.
- i_gnt  out  1  fetch request accepted (1-cycle pulse).
- i_rvalid  out  1  fetch data valid (1-cycle pulse).
- i_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_rvalid  out  1  load data / store acknowledge (1-cycle pulse).
- d_rdata  out  32  load data; 0 for stores.
- m_req, m_we, m_addr[31:0], m_wdata[31:0], m_wstrb[3:0]  out  memory command, held stable until m_gnt.
- m_gnt  in  1  memory accepted the command.
- m_rvalid  in  1  memory response or acknowledge.
- m_rdata  in  32  memory read data.
- busy  out  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: m_req=1, waiting for m_gnt.
  - WAIT: waiting for m_rvalid.
- IDLE arbitration (combinational):
  - An eligible fetch requires i_req && !i_flush.
  - If d_req and an eligible fetch are both present: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - A single requester is granted alone.
- On a grant:
  - Pulse the matching gnt.
  - Latch owner, address, we, wdata and wstrb. Fetch commands force m_we=0 and m_wstrb=0.
  - Clear the drop flag; go to REQ.
- REQ → WAIT on m_gnt.
- WAIT → IDLE on m_rvalid:
  - owner=D: pulse d_rvalid. d_rdata = m_rdata for loads, 0 for stores.
  - owner=I and drop clear: pulse i_rvalid with i_rdata = m_rdata.
  - owner=I and drop set: no response pulse.
- Drop flag:
  - Set when i_flush is high while owner=I in REQ or WAIT, including the same cycle as m_rvalid (that response is suppressed).
  - The memory transaction still completes; it is never aborted on the bus.
- starve_cnt (4-bit):
  - Increment on a data grant while i_req is high.
  - Clear on a fetch grant, or in any IDLE cycle with i_req low.
  - Saturates at STARVE_MAX.
- m_rvalid in IDLE or REQ is ignored (protocol error; no response pulse).
- m_gnt outside REQ is ignored.

## Timing
- Reset: state=IDLE, every output 0, starve_cnt=0, drop=0, latched command = 0.
- Reset mid-transaction: the transaction is abandoned with no response pulse, and the arbiter returns to IDLE the next cycle.
- Grant happens in the IDLE cycle where the request is sampled. m_req rises on the following cycle.
- Minimum latency, request to rvalid, is 2 cycles: grant at T, m_gnt at T+1, m_rvalid at T+2, rvalid pulse at T+2 (combinational from m_rvalid, registered state).
- i_rdata/d_rdata are valid only in the rvalid cycle.
- No new grant is issued in the cycle WAIT → IDLE. The next grant is possible one cycle after the response.
- Requesters must hold req/addr/data until their gnt. After gnt they may change.
- d_req and i_req in the same cycle as a flush: the flush only blocks fetch eligibility, so data may still be granted.

## Test plan
- Single fetch: i_req, addr 0x80000000; memory responds m_gnt at T+1 and m_rvalid with 0x00000013 at T+2 → i_gnt at T, i_rvalid at T+2, i_rdata=0x00000013, busy high T+1..T+2.
- Contention: i_req and d_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I. starve_cnt clears after each I grant.
- Store: d_we=1, d_addr 0x80001000, d_wdata 0xDEADBEEF, wstrb 0xF → m_we=1 with those fields stable until m_gnt. d_rvalid pulses with d_rdata=0.
- Flush in flight: fetch granted, i_flush asserted in WAIT, then m_rvalid → no i_rvalid pulse, FSM back in IDLE. A following fetch to 0x80000010 completes normally.
- Flush coincident with m_rvalid → i_rvalid stays 0. Flush coincident with i_req in IDLE and d_req=0 → no grant that cycle.
- Reset in WAIT, then m_rvalid the cycle after reset → no rvalid pulses, all outputs 0, busy=0.
